// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the UART transmit arbiter and its requesters and transmitter.
// The arbiter connects through the master modport; requesters and the transmitter use slave.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic           tx_wr;
  logic [7:0]     tx_data;
  logic           tbre;
  logic [2:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  modport master (
    input  req, req_data, req_last, tbre,
    output ack, tx_wr, tx_data, grant_id, busy, timeout_err
  );

  modport slave (
    output req, req_data, req_last, tbre,
    input  ack, tx_wr, tx_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters,
// with burst locking and a watchdog on transmitter stalls. Runs on mclkx16.
//
// state | meaning
// IDLE  | no grant; pick next requester after rr_ptr
// LOAD  | grant held; write byte when tbre=1, drop grant if req falls
// WAIT  | byte written; dwell, then wait for tbre or watchdog expiry
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CW          = 12
) (
  input  logic              mclkx16,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam logic [1:0]    IDLE    = 2'd0;
  localparam logic [1:0]    LOAD    = 2'd1;
  localparam logic [1:0]    WAIT    = 2'd2;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]    state;
  logic [2:0]    rr_ptr;
  logic [2:0]    grant_id;
  logic          last_q;
  logic [1:0]    dwell;
  logic [CW-1:0] wd;
  logic [N-1:0]  ack;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic          timeout_err;

  logic          sel_hi_vld;
  logic          sel_any_vld;
  logic [2:0]    sel_hi;
  logic [2:0]    sel_any;
  logic [2:0]    sel_id;
  logic          g_req;
  logic          g_last;
  logic [7:0]    g_data;
  logic [N-1:0]  g_onehot;

  // Lowest requester above rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    sel_hi_vld  = 1'b0;
    sel_any_vld = 1'b0;
    sel_hi      = 3'd0;
    sel_any     = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i] && (3'(i) > rr_ptr)) begin
        sel_hi_vld = 1'b1;
        sel_hi     = 3'(i);
      end
      if (bus.req[i]) begin
        sel_any_vld = 1'b1;
        sel_any     = 3'(i);
      end
    end
    sel_id = sel_hi_vld ? sel_hi : sel_any;
  end

  always_comb begin
    g_req    = 1'b0;
    g_last   = 1'b0;
    g_data   = 8'h00;
    g_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == 3'(i)) begin
        g_req       = bus.req[i];
        g_last      = bus.req_last[i];
        g_data      = bus.req_data[8*i +: 8];
        g_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge mclkx16) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 3'(N - 1);
      grant_id    <= 3'd0;
      last_q      <= 1'b0;
      dwell       <= 2'd0;
      wd          <= '0;
      ack         <= '0;
      tx_wr       <= 1'b0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      tx_wr       <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any_vld) begin
            grant_id <= sel_id;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (!g_req) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end else if (bus.tbre) begin
            tx_data <= g_data;
            tx_wr   <= 1'b1;
            ack     <= g_onehot;
            last_q  <= g_last;
            wd      <= '0;
            dwell   <= 2'd3;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // dwell covers the write cycle plus two cycles of tbre fall latency
          if (wd != WD_LAST) wd <= wd + CW'(1);
          if (dwell != 2'd0) dwell <= dwell - 2'd1;
          if ((dwell == 2'd0) && bus.tbre) begin
            if (!last_q && g_req) begin
              state <= LOAD;
            end else begin
              rr_ptr <= grant_id;
              state  <= IDLE;
            end
          end else if ((wd == WD_LAST) && !bus.tbre) begin
            timeout_err <= 1'b1;
            rr_ptr      <= grant_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack;
  assign bus.tx_wr       = tx_wr;
  assign bus.tx_data     = tx_data;
  assign bus.grant_id    = grant_id;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized bursts, checked against
// a transaction-level round-robin model of the expected write sequence.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 4096;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  logic mclkx16 = 1'b0;
  logic reset   = 1'b1;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYC(TO), .CW(12)) dut (
    .mclkx16 (mclkx16),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 mclkx16 = ~mclkx16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] qd [N][64];
  logic       ql [N][64];
  int         len  [N];
  int         pos  [N];
  bit         hold [N];
  exp_t       exp_q [$];
  int         mptr;

  bit   drv_en    = 1'b0;
  bit   auto_tbre = 1'b1;
  int   tbre_cnt  = 0;
  int   cyc = 0, nwr = 0, wr_cyc = 0, to_cnt = 0, to_cyc = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && pos[i] < len[i]) begin
        bus.req[i]             = 1'b1;
        bus.req_data[8*i +: 8] = qd[i][pos[i]];
        bus.req_last[i]        = ql[i][pos[i]];
      end else begin
        bus.req[i]             = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
  endfunction

  function automatic void add_byte(input int i, input logic [7:0] d, input logic l);
    qd[i][len[i]] = d;
    ql[i][len[i]] = l;
    len[i]++;
  endfunction

  // All pending requesters hold req continuously: grants go round-robin from mptr,
  // each grant emits one whole burst, and the finishing requester becomes the pointer.
  function automatic void predict();
    int p [N];
    int c;
    bit last;
    for (int i = 0; i < N; i++) p[i] = pos[i];
    for (int it = 0; it < N * 64; it++) begin
      c = -1;
      for (int k = 1; k <= N; k++)
        if (c < 0 && !hold[(mptr + k) % N] && p[(mptr + k) % N] < len[(mptr + k) % N])
          c = (mptr + k) % N;
      if (c < 0) break;
      last = 1'b0;
      while (!last && p[c] < len[c]) begin
        exp_q.push_back('{id: 3'(c), data: qd[c][p[c]]});
        last = ql[c][p[c]];
        p[c]++;
      end
      mptr = c;
    end
  endfunction

  // Monitor, requester driver and transmitter tbre model, all just after each edge.
  always @(posedge mclkx16) begin
    exp_t e;
    #1;
    cyc++;
    if (bus.tx_wr) begin
      nwr++;
      wr_cyc = cyc;
      chk("wr_pulse_width", 32'(prev_wr), 32'd0);
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_data", 32'(bus.tx_data), 32'(e.data));
        chk("wr_ack", 32'(bus.ack), 32'd1 << e.id);
        chk("wr_gid", 32'(bus.grant_id), 32'(e.id));
      end
      if (auto_tbre) tbre_cnt = $urandom_range(3, 25);
    end else if (bus.ack != '0) begin
      chk("ack_without_wr", 32'(bus.ack), 32'd0);
    end
    prev_wr = bus.tx_wr;
    if (bus.timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (drv_en) begin
      for (int i = 0; i < N; i++) if (bus.ack[i]) pos[i]++;
      drive_reqs();
    end
    if (auto_tbre) begin
      if (tbre_cnt > 0) tbre_cnt--;
      bus.tbre = (tbre_cnt == 0);
    end
  end

  task automatic do_reset();
    drv_en       = 1'b0;
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) begin
      len[i]  = 0;
      pos[i]  = 0;
      hold[i] = 1'b0;
    end
    exp_q.delete();
    mptr     = N - 1;
    tbre_cnt = 0;
    reset    = 1'b1;
    repeat (2) @(posedge mclkx16);
    #2 reset = 1'b0;
  endtask

  task automatic start_drv();
    drv_en = 1'b1;
    drive_reqs();
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (nwr < n && k < budget) begin
      @(posedge mclkx16);
      #2;
      k++;
    end
    if (nwr < n) chk("wait_wr_timeout", 32'(nwr), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < budget) begin
      @(posedge mclkx16);
      #2;
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base, k;
    bus.tbre = 1'b1;

    // reset values
    do_reset();
    chk("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);

    // single byte and request-to-write latency
    add_byte(0, 8'h0F, 1'b1);
    predict();
    start_drv();
    @(posedge mclkx16); #2;
    chk("lat_load_busy", 32'(bus.busy), 32'd1);
    chk("lat_load_wr", 32'(bus.tx_wr), 32'd0);
    @(posedge mclkx16); #2;
    chk("lat_wr", 32'(bus.tx_wr), 32'd1);
    chk("lat_ack", 32'(bus.ack), 32'd1);
    wait_idle(200);
    chk("single_gid", 32'(bus.grant_id), 32'd0);

    // round robin with all four requesting
    do_reset();
    base = nwr;
    for (int i = 0; i < N; i++) add_byte(i, 8'hA0 + 8'(i), 1'b1);
    add_byte(0, 8'hA0, 1'b1);
    predict();
    start_drv();
    wait_idle(500);
    chk("rr_count", 32'(nwr - base), 32'd5);

    // locked burst from requester 2 while requester 1 waits
    do_reset();
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b0);
    add_byte(2, 8'h33, 1'b1);
    add_byte(1, 8'h55, 1'b1);
    hold[1] = 1'b1;
    exp_q.push_back('{id: 3'd2, data: 8'h11});
    exp_q.push_back('{id: 3'd2, data: 8'h22});
    exp_q.push_back('{id: 3'd2, data: 8'h33});
    exp_q.push_back('{id: 3'd1, data: 8'h55});
    base = nwr;
    start_drv();
    wait_wr(base + 1, 50);
    hold[1] = 1'b0;
    wait_idle(500);

    // transmitter stall and watchdog recovery
    do_reset();
    auto_tbre = 1'b0;
    bus.tbre  = 1'b1;
    add_byte(0, 8'h77, 1'b1);
    add_byte(1, 8'h88, 1'b1);
    predict();
    base = nwr;
    start_drv();
    wait_wr(base + 1, 50);
    bus.tbre = 1'b0;
    k = 0;
    while (to_cnt == 0 && k < TO + 50) begin
      @(posedge mclkx16); #2;
      k++;
    end
    chk("to_count", 32'(to_cnt), 32'd1);
    chk("to_delay", 32'(to_cyc - wr_cyc), 32'(TO));
    chk("to_idle", 32'(bus.busy), 32'd0);
    @(posedge mclkx16); #2;
    chk("to_pulse_width", 32'(bus.timeout_err), 32'd0);
    chk("to_next_gid", 32'(bus.grant_id), 32'd1);
    chk("to_next_busy", 32'(bus.busy), 32'd1);
    bus.tbre  = 1'b1;
    auto_tbre = 1'b1;
    wait_idle(200);

    // abandon in LOAD moves the pointer to the abandoning requester
    do_reset();
    add_byte(1, 8'hC1, 1'b1);
    predict();
    start_drv();
    wait_idle(200);
    drv_en    = 1'b0;
    auto_tbre = 1'b0;
    bus.tbre  = 1'b0;
    bus.req   = 4'b1000;
    @(posedge mclkx16); #2;
    chk("abn_gid", 32'(bus.grant_id), 32'd3);
    chk("abn_load_busy", 32'(bus.busy), 32'd1);
    @(posedge mclkx16); #2;
    bus.req = 4'b0000;
    @(posedge mclkx16); #2;
    chk("abn_idle", 32'(bus.busy), 32'd0);
    chk("abn_no_wr", 32'(bus.tx_wr), 32'd0);
    chk("abn_no_ack", 32'(bus.ack), 32'd0);
    mptr = 3;
    add_byte(0, 8'hD0, 1'b1);
    add_byte(2, 8'hD2, 1'b1);
    predict();
    bus.tbre  = 1'b1;
    auto_tbre = 1'b1;
    start_drv();
    wait_idle(300);

    // reset one cycle after a write, mid-burst
    do_reset();
    add_byte(1, 8'hF1, 1'b0);
    add_byte(1, 8'hF2, 1'b1);
    predict();
    base = nwr;
    start_drv();
    wait_wr(base + 1, 50);
    @(posedge mclkx16); #2;
    reset  = 1'b1;
    drv_en = 1'b0;
    @(posedge mclkx16); #2;
    chk("mrst_tx_wr", 32'(bus.tx_wr), 32'd0);
    chk("mrst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("mrst_ack", 32'(bus.ack), 32'd0);
    chk("mrst_gid", 32'(bus.grant_id), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_timeout", 32'(bus.timeout_err), 32'd0);
    do_reset();
    add_byte(1, 8'hF3, 1'b1);
    add_byte(0, 8'hF0, 1'b1);
    predict();
    start_drv();
    wait_idle(300);

    // randomized bursts across all requesters
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        int nb;
        pos[i] = 0;
        len[i] = 0;
        nb = $urandom_range(0, 5);
        for (int b = 0; b < nb; b++)
          add_byte(i, 8'($urandom), (b == nb - 1) || ($urandom_range(0, 2) == 0));
      end
      predict();
      start_drv();
      wait_idle(3000);
    end
    chk("to_total", 32'(to_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
